result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Sits directly downstream of the last weight_comp_cell in the systolic chain and consumes its flagged result stream: MSB = valid, low DATA_WIDTH bits = dot-product accumulator.
- Numbers each vector's NEURON_AMOUNT results in arrival order and requantises them (right shift plus unsigned saturation).
- Buffers results in a FIFO and presents them on a valid/ready interface with a last marker.
- Reports a per-vector argmax for classification.

Parameters:
- DATA_WIDTH, 32, width of the accumulator field in input_result.
- NEURON_AMOUNT, 4, results per input vector (number of cells in the chain).
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.
- SHIFT, 0, right shift applied before saturation.
- OUT_WIDTH, 8, width of the requantised output value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- input_result  input  DATA_WIDTH+1  chain result; bit DATA_WIDTH = valid, [DATA_WIDTH-1:0] = unsigned accumulator.
- out_value  output  OUT_WIDTH  requantised result at the FIFO head.
- out_index  output  DATA_WIDTH  neuron number 0..NEURON_AMOUNT-1 of the head entry.
- out_last  output  1  head entry is the final result of its vector.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts the head entry this cycle.
- argmax_index  output  DATA_WIDTH  index of the largest result of the most recently completed vector.
- argmax_valid  output  1  one-cycle pulse when argmax_index updates.
- overflow  output  1  sticky; set when a valid result is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n=0 at a rising edge): the following are all cleared:
  - out_valid, out_value, out_index, out_last;
  - argmax_index, argmax_valid, overflow;
  - FIFO pointers and count, neuron counter, running max value and index.
- Reset is synchronous and applies mid-vector: a partially collected vector is discarded and the next valid result is numbered 0.
- Capture: a result is captured only when input_result[DATA_WIDTH]=1. A value of 0 means idle, whatever the low bits hold. Valid results may arrive back-to-back on every cycle.
- Neuron counter:
  - A captured result gets index = counter.
  - The counter increments and wraps from NEURON_AMOUNT-1 to 0.
  - last = (counter == NEURON_AMOUNT-1).
- Requantisation (combinational at capture): q = acc >> SHIFT. out_value = 2^OUT_WIDTH-1 if q ≥ 2^OUT_WIDTH, else q[OUT_WIDTH-1:0].
- Push rule:
  - The entry {value, index, last} is written when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set (it stays 1 until reset).
  - The counter still advances on a dropped result, so indices stay aligned.
- Pop rule: pop = out_valid && out_ready. The head advances on that edge.
- FIFO behaviour:
  - First-word fall-through.
  - out_value, out_index and out_last are driven from the head entry; they hold stable while out_valid=1 and out_ready=0.
  - When the FIFO is empty, out_valid=0 and the data outputs are don't-care.
- Simultaneous push and pop: count is unchanged. With count=1, the new entry becomes the head on the following cycle.
- Latency: a valid result at edge k with the FIFO empty gives out_valid=1 after edge k, i.e. visible in the cycle after capture. Latency is 1.
- Argmax:
  - Compares the unshifted accumulator acc, not the saturated value.
  - Index 0 always loads the running max.
  - For later indices, the running max updates only when acc > max. On ties the lower index wins.
  - On capture of the last result, argmax_index is registered with the final winner (including that result) and argmax_valid=1 for exactly one cycle.
  - Dropped results still take part in argmax.
- Pointer wrap-around: pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an explicit count register.

Test Plan:
- NEURON_AMOUNT=4, SHIFT=0, out_ready=1. Inject valid results 10, 300, 7, 42 on consecutive cycles → out entries (10,0,0), (255,1,0), (7,2,0), (42,3,1), one per cycle, each 1 cycle after its input. argmax_index=1 with argmax_valid pulsing once, 1 cycle after the 42 is captured.
- SHIFT=2, single vector 4, 1023, 1024, 0 → out_value 1, 255, 255, 0. Tie rule check with 5, 9, 9, 2 → argmax_index=1.
- out_ready=0, FIFO_DEPTH=8, 12 back-to-back valid results → first 8 held in order with head stable; overflow=1 from the 9th. Then out_ready=1 → exactly 8 entries drain with indices 0,1,2,3,0,1,2,3. The next vector's first result is numbered 0 (index alignment after drops).
- FIFO full with out_ready=1 and a valid result arriving in the same cycle → result accepted, no overflow, count remains 8.
- Idle cycles with input_result = {1'b0, 32'hDEADBEEF} between valid results → nothing captured, counter unchanged.
- Assert rst_n=0 for one cycle after 2 results of a vector → all outputs 0 and FIFO empty. Next 4 results are numbered 0..3 and produce one argmax_valid pulse.

Source files
------------

// File: rtl/result_collector.sv
// Collects the flagged result stream from the end of the systolic chain:
// numbers, requantises and buffers each result, and tracks a per-vector argmax.
module result_collector #(
    parameter int DATA_WIDTH    = 32,
    parameter int NEURON_AMOUNT = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int SHIFT         = 0,
    parameter int OUT_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH:0]   input_result,
    output logic [OUT_WIDTH-1:0]  out_value,
    output logic [DATA_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] argmax_index,
    output logic                  argmax_valid,
    output logic                  overflow
);

    localparam int CW = (NEURON_AMOUNT > 1) ? $clog2(NEURON_AMOUNT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int QW = PW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NEURON_AMOUNT - 1);
    localparam logic [QW-1:0] DEPTH_C  = QW'(FIFO_DEPTH);

    // Capture-side decode
    logic                  cap;
    logic [DATA_WIDTH-1:0] acc;
    logic                  is_last;
    logic [DATA_WIDTH-1:0] q_wide;
    logic [OUT_WIDTH-1:0]  q_val;

    // FIFO storage (no reset needed: outputs are gated by out_valid)
    logic [OUT_WIDTH-1:0] mem_val_q  [FIFO_DEPTH];
    logic [CW-1:0]        mem_idx_q  [FIFO_DEPTH];
    logic                 mem_last_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [QW-1:0] count_q,  count_d;
    logic          pop, push;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
    logic [CW-1:0]         max_idx_q, max_idx_d;
    logic [CW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] win_val;
    logic [DATA_WIDTH-1:0] am_idx_q, am_idx_d;
    logic                  am_vld_q, am_vld_d;
    logic                  ovf_q, ovf_d;

    assign cap     = input_result[DATA_WIDTH];
    assign acc     = input_result[DATA_WIDTH-1:0];
    assign is_last = (cnt_q == LAST_IDX);

    // Requantise: shift, then clamp to the unsigned output range
    always_comb begin
        q_wide = acc >> SHIFT;
        if ((q_wide >> OUT_WIDTH) != '0) begin
            q_val = '1;
        end else begin
            q_val = q_wide[OUT_WIDTH-1:0];
        end
    end

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push      = cap & ((count_q != DEPTH_C) | pop);

    assign out_value = out_valid ? mem_val_q[rd_ptr_q] : '0;
    assign out_index = out_valid ? DATA_WIDTH'(mem_idx_q[rd_ptr_q]) : '0;
    assign out_last  = out_valid & mem_last_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + QW'(1);
            2'b01:   count_d = count_q - QW'(1);
            default: count_d = count_q;
        endcase
    end

    // Running max: index 0 always loads, later entries only on strict '>'
    always_comb begin
        win_val = max_val_q;
        win_idx = max_idx_q;
        if ((cnt_q == '0) || (acc > max_val_q)) begin
            win_val = acc;
            win_idx = cnt_q;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        am_idx_d  = am_idx_q;
        am_vld_d  = 1'b0;
        ovf_d     = ovf_q;
        if (cap) begin
            cnt_d     = is_last ? '0 : cnt_q + CW'(1);
            max_val_d = win_val;
            max_idx_d = win_idx;
            if (!push) ovf_d = 1'b1;
            if (is_last) begin
                am_idx_d = DATA_WIDTH'(win_idx);
                am_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_val_q[wr_ptr_q]  <= q_val;
            mem_idx_q[wr_ptr_q]  <= cnt_q;
            mem_last_q[wr_ptr_q] <= is_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            am_idx_q  <= '0;
            am_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            am_idx_q  <= am_idx_d;
            am_vld_q  <= am_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign argmax_index = am_idx_q;
    assign argmax_valid = am_vld_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: one SHIFT=0 instance for the main
// sequence and a SHIFT=2 instance for the requantisation vector.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] in1, in2;
    logic        rdy1, rdy2;

    logic [7:0]  v1, v2;
    logic [31:0] i1, i2, am1, am2;
    logic        l1, l2, ov1, ov2, amv1, amv2, ovf1, ovf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_collector #(.SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .input_result(in1),
        .out_value(v1), .out_index(i1), .out_last(l1), .out_valid(ov1),
        .out_ready(rdy1), .argmax_index(am1), .argmax_valid(amv1),
        .overflow(ovf1)
    );

    result_collector #(.SHIFT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .input_result(in2),
        .out_value(v2), .out_index(i2), .out_last(l2), .out_valid(ov2),
        .out_ready(rdy2), .argmax_index(am2), .argmax_valid(amv2),
        .overflow(ovf2)
    );

    function automatic logic [32:0] vr(input int unsigned v);
        return {1'b1, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int v, input int idx, input bit last);
        chk({tag, "_valid"}, 64'(ov1), 64'(1));
        chk({tag, "_value"}, 64'(v1), 64'(v));
        chk({tag, "_index"}, 64'(i1), 64'(idx));
        chk({tag, "_last"},  64'(l1), 64'(last));
    endtask

    initial begin
        rst_n = 1'b0; in1 = '0; in2 = '0; rdy1 = 1'b1; rdy2 = 1'b1;
        tick(); tick();
        chk("rst_valid",  64'(ov1),  0);
        chk("rst_value",  64'(v1),   0);
        chk("rst_index",  64'(i1),   0);
        chk("rst_last",   64'(l1),   0);
        chk("rst_am",     64'(am1),  0);
        chk("rst_amv",    64'(amv1), 0);
        chk("rst_ovf",    64'(ovf1), 0);
        rst_n = 1'b1;

        // Basic vector, saturation of 300, argmax on the last capture
        in1 = vr(10);  tick(); chk_head("v1e0", 10, 0, 0);
        in1 = vr(300); tick(); chk_head("v1e1", 255, 1, 0);
        in1 = vr(7);   tick(); chk_head("v1e2", 7, 2, 0);
        chk("v1_amv_early", 64'(amv1), 0);
        in1 = vr(42);  tick(); chk_head("v1e3", 42, 3, 1);
        chk("v1_amv", 64'(amv1), 1);
        chk("v1_am",  64'(am1),  1);
        in1 = '0;      tick();
        chk("v1_amv_pulse", 64'(amv1), 0);
        chk("v1_am_hold",   64'(am1),  1);
        chk("v1_empty",     64'(ov1),  0);

        // Idle words with junk payload between valid results; tie rule
        in1 = {1'b0, 32'hDEADBEEF}; tick(); chk("idle0_empty", 64'(ov1), 0);
        in1 = vr(5); tick(); chk_head("tie0", 5, 0, 0);
        in1 = {1'b0, 32'hDEADBEEF}; tick(); chk("idle1_empty", 64'(ov1), 0);
        in1 = {1'b0, 32'hDEADBEEF}; tick();
        in1 = vr(9); tick(); chk_head("tie1", 9, 1, 0);
        in1 = vr(9); tick(); chk_head("tie2", 9, 2, 0);
        in1 = vr(2); tick(); chk_head("tie3", 2, 3, 1);
        chk("tie_amv", 64'(amv1), 1);
        chk("tie_am",  64'(am1),  1);
        in1 = '0; tick();

        // SHIFT=2 instance
        in2 = vr(4);    tick(); chk("s2e0_v", 64'(v2), 1);   chk("s2e0_i", 64'(i2), 0);
        in2 = vr(1023); tick(); chk("s2e1_v", 64'(v2), 255); chk("s2e1_i", 64'(i2), 1);
        in2 = vr(1024); tick(); chk("s2e2_v", 64'(v2), 255); chk("s2e2_i", 64'(i2), 2);
        in2 = vr(0);    tick(); chk("s2e3_v", 64'(v2), 0);   chk("s2e3_l", 64'(l2), 1);
        chk("s2_amv", 64'(amv2), 1);
        chk("s2_am",  64'(am2),  2);
        in2 = '0; tick();
        chk("s2_amv_pulse", 64'(amv2), 0);
        chk("s2_empty",     64'(ov2),  0);
        chk("s2_ovf",       64'(ovf2), 0);

        // Fill with out_ready low: 8 held, 4 dropped
        rdy1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in1 = vr(100 + i);
            tick();
            chk("ovf_head_value", 64'(v1), 100);
            chk("ovf_head_index", 64'(i1), 0);
            if (i == 7) chk("ovf_before", 64'(ovf1), 0);
            if (i == 8) chk("ovf_after",  64'(ovf1), 1);
        end
        in1 = '0; rdy1 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk_head("drain", 100 + j, j % 4, (j % 4) == 3);
            tick();
        end
        chk("drain_empty",  64'(ov1),  0);
        chk("ovf_sticky",   64'(ovf1), 1);

        // Alignment after drops, then reset mid-vector
        rdy1 = 1'b0;
        in1 = vr(500); tick(); chk_head("align0", 500 > 255 ? 255 : 500, 0, 0);
        in1 = vr(600); tick(); chk("align_cnt", 64'(ov1), 1);
        in1 = '0; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("mrst_valid", 64'(ov1),  0);
        chk("mrst_value", 64'(v1),   0);
        chk("mrst_index", 64'(i1),   0);
        chk("mrst_last",  64'(l1),   0);
        chk("mrst_am",    64'(am1),  0);
        chk("mrst_amv",   64'(amv1), 0);
        chk("mrst_ovf",   64'(ovf1), 0);
        rdy1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in1 = vr(k + 1);
            tick();
            chk_head("post_rst", k + 1, k, k == 3);
            chk("post_rst_amv", 64'(amv1), (k == 3) ? 1 : 0);
        end
        chk("post_rst_am", 64'(am1), 3);
        in1 = '0; tick();
        chk("post_rst_amv_end", 64'(amv1), 0);

        // Full FIFO with pop and push in the same cycle
        rdy1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in1 = vr(200 + i);
            tick();
        end
        chk_head("full_head", 200, 0, 0);
        rdy1 = 1'b1; in1 = vr(250); tick();
        chk("full_pp_ovf", 64'(ovf1), 0);
        in1 = '0;
        for (int j = 0; j < 8; j++) begin
            chk_head("full_drain", (j < 7) ? 201 + j : 250, (j + 1) % 4, ((j + 1) % 4) == 3);
            tick();
        end
        chk("full_drain_empty", 64'(ov1), 0);
        chk("full_ovf_end",     64'(ovf1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
